sad_row_param: RTL
==================

// Module: sad_row_param
// PURPOSE
//  Parametrised SAD row for block motion estimation, replacing the fixed-size PE row.
//  - N_CAND parallel PEs each accumulate the sum of absolute differences between one
//    current-block pixel stream and its own candidate pixel stream.
//  - After BLK_SIZE*BLK_SIZE accepted beats, a sequential minimum search picks the best
//    candidate, which is returned on a valid/ready result port.
//  - Sits between the search-window buffer (pixel source) and the motion-vector collector.
// PARAMETERS
//  PIX_W     8   pixel width, unsigned
//  BLK_SIZE  8   block edge; NPIX = BLK_SIZE*BLK_SIZE beats per block
//  N_CAND    8   number of parallel candidates/PEs (>=1)
//  ACC_W     16  accumulator and SAD width
//  IDX_W     8   candidate index width (2^IDX_W >= N_CAND)
// PORTS
//  clk        in   1             clock, all logic on rising edge
//  reset      in   1             synchronous, active-low (0 = reset)
//  start      in   1             pulse; begins a block, honoured only in IDLE
//  cur_pix    in   PIX_W         current-block pixel
//  ref_pix    in   N_CAND*PIX_W  candidate pixels; PE k uses bits [k*PIX_W +: PIX_W]
//  cur_valid  in   1             cur_pix/ref_pix valid
//  cur_ready  out  1             beat accepted when cur_valid & cur_ready
//  thr_en     in   1             enable match threshold, sampled at start
//  threshold  in   ACC_W         match threshold, sampled at start
//  res_valid  out  1             result valid, held until res_ready
//  res_ready  in   1             result consumer ready
//  best_sad   out  ACC_W         minimum SAD
//  best_idx   out  IDX_W         index of the minimum candidate
//  match_ok   out  1             thr_en & (best_sad < threshold)
//  busy       out  1             FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE; all accumulators and the beat counter = 0; cur_ready=0, res_valid=0,
//    best_sad=all ones, best_idx=0, match_ok=0, busy=0.
//  - Reset mid-operation aborts the block; no result is produced.
//  - FSM: IDLE -start-> ACCUM -NPIX beats-> DRAIN(2 cycles) -> COMPARE(N_CAND cycles)
//    -> OUTPUT -res_ready-> IDLE.
//  - IDLE: start clears all accumulators and the running minimum to all ones, and latches
//    thr_en/threshold.
//  - ACCUM:
//    - cur_ready=1; only in ACCUM.
//    - Bubbles (cur_valid=0) are allowed and do not count as beats.
//    - PE pipeline, 2 stages: stage 1 = PIX_W+1-bit difference; stage 2 = absolute value.
//      The accumulator adds the stage-2 result only for valid beats.
//    - Accumulator saturates at 2^ACC_W-1 and never wraps.
//    - After the NPIX-th beat, cur_ready drops the next cycle.
//  - DRAIN: 2 cycles to flush the PE pipeline; no input is accepted.
//  - COMPARE: scans PE 0..N_CAND-1, one per cycle. Strict less-than, so ties keep the
//    lowest index.
//  - OUTPUT:
//    - res_valid=1; best_sad, best_idx and match_ok are stable while res_valid & !res_ready.
//    - Handshake cycle -> IDLE.
//  - Latency: res_valid rises exactly N_CAND+3 cycles after the cycle accepting the last beat.
//  - start outside IDLE is ignored, including start on the res handshake cycle.
//  - busy=1 in every state except IDLE.
// TESTING
//  1 N_CAND=4, BLK=2; cur=10 all beats; ref=[10,12,7,200] -> SAD=[0,8,12,760]; best_idx=0,
//    best_sad=0; res_valid exactly 7 cycles after the 4th beat.
//  2 Ties: ref k=1 and k=3 both give SAD=5, others larger -> best_idx=1.
//  3 Saturation: ACC_W=8, cur=0, ref=255, NPIX=4 -> PE SAD=255, not 1020 mod 256.
//  4 Bubbles: cur_valid toggled 1,0,1,0... -> identical result to the back-to-back stream;
//    exactly NPIX beats are accepted.
//  5 Backpressure/threshold: res_ready=0 for 10 cycles -> outputs stable; thr_en=1 with
//    threshold=5 and best=4 -> match_ok=1; threshold=4 -> match_ok=0; start while busy is
//    ignored.
//  6 reset=0 during ACCUM -> next cycle busy=0, res_valid=0; new start yields a correct
//    fresh result.

Source files
------------

// File: rtl/sad_row_param_if.sv
// Pixel-stream, threshold and result bundle for the parametrised SAD row.
interface sad_row_param_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned N_CAND = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned IDX_W  = 8
);
  logic                      start;
  logic [PIX_W-1:0]          cur_pix;
  logic [N_CAND*PIX_W-1:0]   ref_pix;
  logic                      cur_valid;
  logic                      cur_ready;
  logic                      thr_en;
  logic [ACC_W-1:0]          threshold;
  logic                      res_valid;
  logic                      res_ready;
  logic [ACC_W-1:0]          best_sad;
  logic [IDX_W-1:0]          best_idx;
  logic                      match_ok;
  logic                      busy;

  modport master (
    output start, cur_pix, ref_pix, cur_valid, thr_en, threshold, res_ready,
    input  cur_ready, res_valid, best_sad, best_idx, match_ok, busy
  );

  modport slave (
    input  start, cur_pix, ref_pix, cur_valid, thr_en, threshold, res_ready,
    output cur_ready, res_valid, best_sad, best_idx, match_ok, busy
  );
endinterface

// File: rtl/sad_row_param.sv
// Parametrised SAD row: N_CAND PEs accumulate |cur - ref| over a BLK_SIZE x BLK_SIZE
// block, then a one-candidate-per-cycle scan returns the minimum on a valid/ready port.
module sad_row_param #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned BLK_SIZE = 8,
  parameter int unsigned N_CAND   = 8,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned IDX_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  sad_row_param_if.slave  bus
);

  localparam int unsigned NPIX  = BLK_SIZE * BLK_SIZE;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_COMPARE,
    S_OUTPUT
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               drain_q;
  logic [IDX_W-1:0]   scan_q;
  logic               v1_q, v2_q;
  logic [PIX_W:0]     diff_q [N_CAND];
  logic [PIX_W:0]     diff_d [N_CAND];
  logic [PIX_W-1:0]   abs_q  [N_CAND];
  logic [PIX_W-1:0]   abs_d  [N_CAND];
  logic [ACC_W:0]     sum_w  [N_CAND];
  logic [ACC_W-1:0]   acc_q  [N_CAND];
  logic [ACC_W-1:0]   acc_d  [N_CAND];
  logic [ACC_W-1:0]   min_q;
  logic [IDX_W-1:0]   idx_q;
  logic               thr_en_q;
  logic [ACC_W-1:0]   thr_q;
  logic               match_q;
  logic               cur_ready_q;
  logic               res_valid_q;
  logic               busy_q;

  logic               beat;
  logic               last_beat;
  logic [ACC_W-1:0]   sel_sad;
  logic               take;
  logic [ACC_W-1:0]   min_d;
  logic [IDX_W-1:0]   idx_d;
  logic               last_scan;

  assign beat      = bus.cur_valid & cur_ready_q;
  assign last_beat = beat && (cnt_q == CNT_W'(NPIX - 1));

  // PE datapath: signed difference, absolute value, saturating accumulate
  always_comb begin
    for (int unsigned k = 0; k < N_CAND; k++) begin
      diff_d[k] = {1'b0, bus.cur_pix} - {1'b0, bus.ref_pix[k*PIX_W +: PIX_W]};
      abs_d[k]  = diff_q[k][PIX_W] ? PIX_W'(-diff_q[k]) : diff_q[k][PIX_W-1:0];
      sum_w[k]  = {1'b0, acc_q[k]} + (ACC_W+1)'(abs_q[k]);
      acc_d[k]  = sum_w[k][ACC_W] ? '1 : sum_w[k][ACC_W-1:0];
    end
  end

  // Minimum search: select the scanned PE; strict less-than keeps the lowest index on ties
  always_comb begin
    sel_sad = '1;
    for (int unsigned k = 0; k < N_CAND; k++) begin
      if (scan_q == IDX_W'(k)) sel_sad = acc_q[k];
    end
    take      = sel_sad < min_q;
    min_d     = take ? sel_sad : min_q;
    idx_d     = take ? scan_q : idx_q;
    last_scan = scan_q == IDX_W'(N_CAND - 1);
  end

  // PE pipeline data registers (qualified by v1_q/v2_q, so no reset needed)
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_CAND; k++) begin
      diff_q[k] <= diff_d[k];
      abs_q[k]  <= abs_d[k];
    end
  end

  // Control FSM, accumulators, running minimum and registered result outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      scan_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      for (int unsigned k = 0; k < N_CAND; k++) acc_q[k] <= '0;
      min_q       <= '1;
      idx_q       <= '0;
      thr_en_q    <= 1'b0;
      thr_q       <= '0;
      match_q     <= 1'b0;
      cur_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      v1_q <= beat;
      v2_q <= v1_q;
      for (int unsigned k = 0; k < N_CAND; k++) begin
        if (state_q == S_IDLE && bus.start) acc_q[k] <= '0;
        else if (v2_q)                      acc_q[k] <= acc_d[k];
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_ACCUM;
            cnt_q       <= '0;
            min_q       <= '1;
            idx_q       <= '0;
            match_q     <= 1'b0;
            thr_en_q    <= bus.thr_en;
            thr_q       <= bus.threshold;
            cur_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (beat) cnt_q <= cnt_q + 1'b1;
          if (last_beat) begin
            cur_ready_q <= 1'b0;
            drain_q     <= 1'b0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            scan_q  <= '0;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          min_q <= min_d;
          idx_q <= idx_d;
          if (last_scan) begin
            match_q     <= thr_en_q & (min_d < thr_q);
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cur_ready = cur_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.best_sad  = min_q;
  assign bus.best_idx  = idx_q;
  assign bus.match_ok  = match_q;
  assign bus.busy      = busy_q;

endmodule
